// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - BCD calendar constants, FSM encoding and leap-year / month-length helpers
package cal_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t MON_JAN = 8'h01;
    localparam bcd2_t MON_FEB = 8'h02;
    localparam bcd2_t MON_MAR = 8'h03;
    localparam bcd2_t MON_APR = 8'h04;
    localparam bcd2_t MON_MAY = 8'h05;
    localparam bcd2_t MON_JUN = 8'h06;
    localparam bcd2_t MON_JUL = 8'h07;
    localparam bcd2_t MON_AUG = 8'h08;
    localparam bcd2_t MON_SEP = 8'h09;
    localparam bcd2_t MON_OCT = 8'h10;
    localparam bcd2_t MON_NOV = 8'h11;
    localparam bcd2_t MON_DEC = 8'h12;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Divisibility by 4 straight from BCD: tens parity selects the allowed units digits.
    function automatic logic bcd_mod4(input bcd2_t v);
        if (v[4])
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic is_leap(input bcd2_t century, input bcd2_t yy);
        return bcd_mod4(yy) && ((yy != 8'h00) || bcd_mod4(century));
    endfunction

    function automatic bcd2_t days_in_month(input bcd2_t month, input logic leap);
        case (month)
            MON_FEB:                            return leap ? 8'h29 : 8'h28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: return 8'h30;
            MON_JAN, MON_MAR, MON_MAY, MON_JUL,
            MON_AUG, MON_OCT, MON_DEC:          return 8'h31;
            default:                            return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/calendar_counter_if.sv
// rtl/calendar_counter_if.sv - date-load valid/ready bundle; load_dow present with CAL_DOW_EN
interface calendar_counter_if #(
    parameter int YEAR_DIGITS = 4
);
    logic                     load_valid;
    logic                     load_ready;
    logic [7:0]               load_day;
    logic [7:0]               load_month;
    logic [4*YEAR_DIGITS-1:0] load_year;
    logic                     load_err;
`ifdef CAL_DOW_EN
    logic [2:0]               load_dow;

    modport master (
        output load_valid, load_day, load_month, load_year, load_dow,
        input  load_ready, load_err
    );
    modport slave (
        input  load_valid, load_day, load_month, load_year, load_dow,
        output load_ready, load_err
    );
`else
    modport master (
        output load_valid, load_day, load_month, load_year,
        input  load_ready, load_err
    );
    modport slave (
        input  load_valid, load_day, load_month, load_year,
        output load_ready, load_err
    );
`endif
endinterface

// File: rtl/bcd_inc_wrap.sv
// rtl/bcd_inc_wrap.sv - one BCD byte incrementer that wraps from max back to min
module bcd_inc_wrap
    import cal_pkg::*;
(
    input  bcd2_t value,
    input  logic  inc,
    input  bcd2_t max_val,
    input  bcd2_t min_val,
    output bcd2_t next,
    output logic  wrap
);

    always_comb begin
        next = value;
        wrap = 1'b0;
        if (inc) begin
            if (value >= max_val) begin
                next = min_val;
                wrap = 1'b1;
            end else if (value[3:0] >= 4'd9) begin
                next = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/calendar_counter.sv
// rtl/calendar_counter.sv - BCD day/month/year calendar with validated loads; CAL_DOW_EN adds day-of-week
module calendar_counter
    import cal_pkg::*;
#(
    parameter int          YEAR_DIGITS  = 4,
    parameter bcd2_t       BASE_CENTURY = 8'h20,
    parameter bcd2_t       RESET_DAY    = 8'h01,
    parameter bcd2_t       RESET_MONTH  = 8'h01,
    parameter logic [15:0] RESET_YEAR   = 16'h2000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     day_tick,
    calendar_counter_if.slave        load_if,
    output bcd2_t                    day,
    output bcd2_t                    month,
    output logic [4*YEAR_DIGITS-1:0] year,
    output logic                     month_wrap,
    output logic                     year_wrap
`ifdef CAL_DOW_EN
    ,
    output logic [2:0]               dow
`endif
);

    localparam int YW = 4 * YEAR_DIGITS;

    logic [1:0]    state;
    bcd2_t         cap_day;
    bcd2_t         cap_month;
    logic [YW-1:0] cap_year;
    logic          ok_q;
    logic          pending;

    logic          commit;
    logic          commit_ok;
    logic          tick_now;
    logic          use_cap;
    logic          adv;
    logic          nib_ok;
    logic          date_ok;
    logic          fields_ok;

    bcd2_t         base_day;
    bcd2_t         base_month;
    logic [YW-1:0] base_year;
    logic [15:0]   base_year16;
    bcd2_t         base_cent;
    bcd2_t         dim;

    bcd2_t         day_next;
    bcd2_t         month_next;
    logic [YW-1:0] year_next;
    logic          day_wr;
    logic          mon_wr;
    logic          year_ovf_unused;

    assign load_if.load_ready = (state == ST_IDLE);
    assign commit    = (state == ST_COMMIT);
    assign commit_ok = commit && ok_q;
    assign tick_now  = day_tick || pending;
    // The incrementers see the captured date while validating and on a good commit,
    // so a tick held during the load lands on the new date.
    assign use_cap   = (state == ST_CHECK) || commit_ok;
    assign adv       = tick_now && ((state == ST_IDLE) || commit_ok);

    assign base_day    = use_cap ? cap_day   : day;
    assign base_month  = use_cap ? cap_month : month;
    assign base_year   = use_cap ? cap_year  : year;
    assign base_year16 = 16'(base_year);
    assign base_cent   = (YEAR_DIGITS == 4) ? base_year16[15:8] : BASE_CENTURY;
    assign dim         = days_in_month(base_month, is_leap(base_cent, base_year[7:0]));

    always_comb begin
        nib_ok = (cap_day[7:4] <= 4'd9) && (cap_day[3:0] <= 4'd9) &&
                 (cap_month[7:4] <= 4'd9) && (cap_month[3:0] <= 4'd9);
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (cap_year[4*i +: 4] > 4'd9)
                nib_ok = 1'b0;
        end
    end

    assign date_ok = nib_ok && (cap_month >= MON_JAN) && (cap_month <= MON_DEC) &&
                     (cap_day != 8'h00) && (cap_day <= dim);

    bcd_inc_wrap u_day (
        .value   (base_day),
        .inc     (adv),
        .max_val (dim),
        .min_val (8'h01),
        .next    (day_next),
        .wrap    (day_wr)
    );

    bcd_inc_wrap u_month (
        .value   (base_month),
        .inc     (day_wr),
        .max_val (MON_DEC),
        .min_val (MON_JAN),
        .next    (month_next),
        .wrap    (mon_wr)
    );

    generate
        if (YEAR_DIGITS == 4) begin : g_year4
            bcd2_t lo_next;
            bcd2_t hi_next;
            logic  lo_wrap;
            logic  hi_wrap;

            bcd_inc_wrap u_year_lo (
                .value   (base_year[7:0]),
                .inc     (mon_wr),
                .max_val (8'h99),
                .min_val (8'h00),
                .next    (lo_next),
                .wrap    (lo_wrap)
            );

            bcd_inc_wrap u_year_hi (
                .value   (base_year[15:8]),
                .inc     (lo_wrap),
                .max_val (8'h99),
                .min_val (8'h00),
                .next    (hi_next),
                .wrap    (hi_wrap)
            );

            assign year_next       = {hi_next, lo_next};
            assign year_ovf_unused = hi_wrap;
        end else begin : g_year2
            logic lo_wrap;

            bcd_inc_wrap u_year_lo (
                .value   (base_year[7:0]),
                .inc     (mon_wr),
                .max_val (8'h99),
                .min_val (8'h00),
                .next    (year_next),
                .wrap    (lo_wrap)
            );

            assign year_ovf_unused = lo_wrap;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cap_day          <= 8'h00;
            cap_month        <= 8'h00;
            cap_year         <= '0;
            ok_q             <= 1'b0;
            pending          <= 1'b0;
            load_if.load_err <= 1'b0;
        end else begin
            load_if.load_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pending <= 1'b0;
                    if (load_if.load_valid) begin
                        cap_day   <= load_if.load_day;
                        cap_month <= load_if.load_month;
                        cap_year  <= load_if.load_year;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    ok_q    <= fields_ok;
                    pending <= pending || day_tick;
                    state   <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // A rejected load keeps any held tick for the next IDLE cycle so its
                    // wrap pulses cannot coincide with load_err.
                    load_if.load_err <= !ok_q;
                    pending          <= !ok_q && tick_now;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day        <= RESET_DAY;
            month      <= RESET_MONTH;
            year       <= RESET_YEAR[YW-1:0];
            month_wrap <= 1'b0;
            year_wrap  <= 1'b0;
        end else begin
            month_wrap <= day_wr;
            year_wrap  <= mon_wr;
            if (commit_ok || adv) begin
                day   <= day_next;
                month <= month_next;
                year  <= year_next;
            end
        end
    end

`ifdef CAL_DOW_EN
    logic [2:0] cap_dow;
    logic [2:0] dow_base;

    assign fields_ok = date_ok && (cap_dow <= 3'd6);
    assign dow_base  = commit_ok ? cap_dow : dow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_dow <= 3'd0;
            dow     <= 3'd6;
        end else begin
            if ((state == ST_IDLE) && load_if.load_valid)
                cap_dow <= load_if.load_dow;
            if (commit_ok || adv)
                dow <= adv ? ((dow_base >= 3'd6) ? 3'd0 : dow_base + 3'd1) : dow_base;
        end
    end
`else
    assign fields_ok = date_ok;
`endif

endmodule

// File: tb/tb_calendar_counter.sv
// tb/tb_calendar_counter.sv - directed vector bench for calendar_counter (4-digit and 2-digit/century-21 instances)
module tb_calendar_counter;

    logic        clk;
    logic        rst_n;
    logic        tick_a;
    logic        tick_b;
    logic [7:0]  day_a, month_a, day_b, month_b;
    logic [15:0] year_a;
    logic [7:0]  year_b;
    logic        mw_a, yw_a, mw_b, yw_b;
`ifdef CAL_DOW_EN
    logic [2:0]  dow_a, dow_b;
`endif

    int checks;
    int failures;

    calendar_counter_if #(.YEAR_DIGITS(4)) a_if ();
    calendar_counter_if #(.YEAR_DIGITS(2)) b_if ();

    calendar_counter dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_tick   (tick_a),
        .load_if    (a_if),
        .day        (day_a),
        .month      (month_a),
        .year       (year_a),
        .month_wrap (mw_a),
        .year_wrap  (yw_a)
`ifdef CAL_DOW_EN
        ,
        .dow        (dow_a)
`endif
    );

    calendar_counter #(.YEAR_DIGITS(2), .BASE_CENTURY(8'h21)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_tick   (tick_b),
        .load_if    (b_if),
        .day        (day_b),
        .month      (month_b),
        .year       (year_b),
        .month_wrap (mw_b),
        .year_wrap  (yw_b)
`ifdef CAL_DOW_EN
        ,
        .dow        (dow_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        do_load;
        logic [7:0]  ld_d;
        logic [7:0]  ld_m;
        logic [15:0] ld_y;
        logic        ex_err;
        int          ticks;
        logic [7:0]  ex_d;
        logic [7:0]  ex_m;
        logic [15:0] ex_y;
        logic        ex_mw;
        logic        ex_yw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic dl, input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                       input logic e, input int t, input logic [7:0] xd, input logic [7:0] xm,
                       input logic [15:0] xy, input logic xmw, input logic xyw);
        vec_t v;
        v.do_load = dl; v.ld_d = d; v.ld_m = m; v.ld_y = y; v.ex_err = e; v.ticks = t;
        v.ex_d = xd; v.ex_m = xm; v.ex_y = xy; v.ex_mw = xmw; v.ex_yw = xyw;
        vecs.push_back(v);
    endtask

    task automatic tick(input bit sel_b);
        if (sel_b) tick_b = 1'b1;
        else       tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    // Starts just after a falling edge; returns after the COMMIT edge with load_err sampled.
    task automatic do_load(input bit sel_b, input logic [7:0] d, input logic [7:0] m,
                           input logic [15:0] y, input logic [2:0] w, output logic err);
        int n;
        n = 0;
        while (!(sel_b ? b_if.load_ready : a_if.load_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("load_ready_wait", 32'(sel_b ? b_if.load_ready : a_if.load_ready), 32'd1);
        if (sel_b) begin
            b_if.load_valid = 1'b1; b_if.load_day = d; b_if.load_month = m; b_if.load_year = y[7:0];
`ifdef CAL_DOW_EN
            b_if.load_dow = w;
`endif
        end else begin
            a_if.load_valid = 1'b1; a_if.load_day = d; a_if.load_month = m; a_if.load_year = y;
`ifdef CAL_DOW_EN
            a_if.load_dow = w;
`endif
        end
        @(negedge clk);
        a_if.load_valid = 1'b0;
        b_if.load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        err = sel_b ? b_if.load_err : a_if.load_err;
    endtask

    initial begin
        logic err;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        tick_a   = 1'b0;
        tick_b   = 1'b0;
        a_if.load_valid = 1'b0; a_if.load_day = 8'h00; a_if.load_month = 8'h00; a_if.load_year = 16'h0000;
        b_if.load_valid = 1'b0; b_if.load_day = 8'h00; b_if.load_month = 8'h00; b_if.load_year = 8'h00;
`ifdef CAL_DOW_EN
        a_if.load_dow = 3'd0;
        b_if.load_dow = 3'd0;
`endif

        add(1, 8'h28, 8'h02, 16'h1900, 0, 1, 8'h01, 8'h03, 16'h1900, 1, 0);
        add(1, 8'h28, 8'h02, 16'h2000, 0, 1, 8'h29, 8'h02, 16'h2000, 0, 0);
        add(0, 8'h00, 8'h00, 16'h0000, 0, 1, 8'h01, 8'h03, 16'h2000, 1, 0);
        add(1, 8'h31, 8'h12, 16'h2099, 0, 1, 8'h01, 8'h01, 16'h2100, 1, 1);
        add(1, 8'h31, 8'h04, 16'h2024, 1, 0, 8'h01, 8'h01, 16'h2100, 0, 0);
        add(1, 8'h2A, 8'h01, 16'h2024, 1, 0, 8'h01, 8'h01, 16'h2100, 0, 0);
        add(1, 8'h29, 8'h02, 16'h2100, 1, 0, 8'h01, 8'h01, 16'h2100, 0, 0);
        add(1, 8'h29, 8'h02, 16'h2024, 0, 0, 8'h29, 8'h02, 16'h2024, 0, 0);
        add(1, 8'h29, 8'h02, 16'h2023, 1, 0, 8'h29, 8'h02, 16'h2024, 0, 0);
        add(1, 8'h29, 8'h02, 16'h1600, 0, 1, 8'h01, 8'h03, 16'h1600, 1, 0);
        add(1, 8'h30, 8'h09, 16'h2024, 0, 1, 8'h01, 8'h10, 16'h2024, 1, 0);
        add(1, 8'h09, 8'h09, 16'h2024, 0, 1, 8'h10, 8'h09, 16'h2024, 0, 0);
        add(1, 8'h15, 8'h13, 16'h2024, 1, 0, 8'h10, 8'h09, 16'h2024, 0, 0);
        add(1, 8'h15, 8'h00, 16'h2024, 1, 0, 8'h10, 8'h09, 16'h2024, 0, 0);
        add(1, 8'h00, 8'h05, 16'h2024, 1, 0, 8'h10, 8'h09, 16'h2024, 0, 0);
        add(1, 8'h15, 8'h05, 16'h20A4, 1, 0, 8'h10, 8'h09, 16'h2024, 0, 0);
        add(1, 8'h31, 8'h12, 16'h9999, 0, 1, 8'h01, 8'h01, 16'h0000, 1, 1);
        add(1, 8'h31, 8'h01, 16'h2024, 0, 1, 8'h01, 8'h02, 16'h2024, 1, 0);
        add(1, 8'h30, 8'h11, 16'h2024, 0, 1, 8'h01, 8'h12, 16'h2024, 1, 0);
        add(1, 8'h30, 8'h06, 16'h2025, 0, 0, 8'h30, 8'h06, 16'h2025, 0, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("reset_day",   32'(day_a),   32'h01);
        chk("reset_month", 32'(month_a), 32'h01);
        chk("reset_year",  32'(year_a),  32'h2000);
        chk("reset_ready", 32'(a_if.load_ready), 32'd1);
        chk("reset_pulses", 32'({mw_a, yw_a, a_if.load_err}), 32'd0);
        chk("reset_b_date", 32'({day_b, month_b, year_b}), 32'h010100);
`ifdef CAL_DOW_EN
        chk("reset_dow", 32'(dow_a), 32'd6);
`endif

        tick(0);
`ifdef CAL_DOW_EN
        chk("dow_first_tick", 32'(dow_a), 32'd0);
`endif
        repeat (6) tick(0);
        chk("seven_ticks_date", 32'({day_a, month_a, year_a}), 32'h08012000);
`ifdef CAL_DOW_EN
        chk("dow_seven_ticks", 32'(dow_a), 32'd6);
        do_load(0, 8'h10, 8'h10, 16'h2010, 3'd7, err);
        chk("dow7_err", 32'(err), 32'd1);
        chk("dow7_date_kept", 32'({day_a, month_a, year_a}), 32'h08012000);
        do_load(0, 8'h10, 8'h10, 16'h2010, 3'd3, err);
        chk("dow3_ok", 32'({err, dow_a}), 32'd3);
        tick(0);
        chk("dow3_tick", 32'(dow_a), 32'd4);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].do_load) begin
                do_load(0, vecs[i].ld_d, vecs[i].ld_m, vecs[i].ld_y, 3'd0, err);
                chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].ex_err));
            end
            for (int t = 0; t < vecs[i].ticks; t++) tick(0);
            chk($sformatf("vec%0d_date", i), 32'({day_a, month_a, year_a}),
                32'({vecs[i].ex_d, vecs[i].ex_m, vecs[i].ex_y}));
            chk($sformatf("vec%0d_wraps", i), 32'({mw_a, yw_a}), 32'({vecs[i].ex_mw, vecs[i].ex_yw}));
        end

        // Tick arriving while the load sits in CHECK lands on the newly loaded date.
        a_if.load_valid = 1'b1; a_if.load_day = 8'h15; a_if.load_month = 8'h06; a_if.load_year = 16'h2025;
        @(negedge clk);
        a_if.load_valid = 1'b0;
        tick_a = 1'b1;
        chk("check_ready_low", 32'(a_if.load_ready), 32'd0);
        @(negedge clk);
        tick_a = 1'b0;
        @(negedge clk);
        chk("pending_tick_date", 32'({day_a, month_a, year_a}), 32'h16062025);
        chk("pending_tick_err", 32'(a_if.load_err), 32'd0);

        // Rejected load with a held tick: error first, the tick lands one cycle later.
        a_if.load_valid = 1'b1; a_if.load_day = 8'h31; a_if.load_month = 8'h06; a_if.load_year = 16'h2025;
        @(negedge clk);
        a_if.load_valid = 1'b0;
        tick_a = 1'b1;
        chk("err_lat_check", 32'(a_if.load_err), 32'd0);
        @(negedge clk);
        tick_a = 1'b0;
        chk("err_lat_commit", 32'({a_if.load_err, a_if.load_ready}), 32'd0);
        @(negedge clk);
        chk("err_lat_pulse", 32'(a_if.load_err), 32'd1);
        chk("err_date_kept", 32'({day_a, month_a, year_a}), 32'h16062025);
        @(negedge clk);
        chk("err_pulse_end", 32'(a_if.load_err), 32'd0);
        chk("err_then_tick", 32'({day_a, month_a, year_a}), 32'h17062025);

        do_load(1, 8'h28, 8'h02, 16'h0000, 3'd0, err);
        chk("b_load_err", 32'(err), 32'd0);
        tick(1);
        chk("b_2100_not_leap", 32'({day_b, month_b, year_b}), 32'h010300);
        chk("b_month_wrap", 32'({mw_b, yw_b}), 32'b10);
        do_load(1, 8'h29, 8'h02, 16'h0000, 3'd0, err);
        chk("b_feb29_err", 32'(err), 32'd1);
        do_load(1, 8'h29, 8'h02, 16'h0004, 3'd0, err);
        chk("b_feb29_04", 32'({err, day_b, month_b, year_b}), 32'h290204);
        do_load(1, 8'h31, 8'h12, 16'h0099, 3'd0, err);
        tick(1);
        chk("b_year_ovf", 32'({day_b, month_b, year_b}), 32'h010100);
        chk("b_year_wrap", 32'({mw_b, yw_b}), 32'b11);

        // Reset while a load is in CHECK throws the capture away.
        a_if.load_valid = 1'b1; a_if.load_day = 8'h10; a_if.load_month = 8'h10; a_if.load_year = 16'h2010;
        @(negedge clk);
        a_if.load_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midload_reset_date", 32'({day_a, month_a, year_a}), 32'h01012000);
        chk("midload_reset_ready", 32'({a_if.load_ready, a_if.load_err}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
